result_tx_ctrl: RTL and testbench

UART transmit controller that drives the board `tx` pin, which is currently tied high. On each fc_net `stop` pulse it sends the recognised digit back to the host as an ASCII line. It is the outbound counterpart of the image-receiving rx_ctrl, using the same 8N1 framing at the same baud rate. Optionally it can also stream the 784-byte (28x28) image RAM back to the host for debug.

---
 rtl/result_tx_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_result_tx_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_tx_ctrl.sv
// result_tx_ctrl: UART 8N1 transmitter that reports each recognised digit
// from fc_net to the host as "<digit>\r\n". Define IMG_DUMP_EN to also
// build the key-triggered dump of the 784-byte image RAM.
module result_tx_ctrl #(
  parameter int CLK_FREQ = 15000000,
  parameter int BAUD     = 115200,
  parameter int BIT_CNT  = CLK_FREQ / BAUD,
  parameter int IMG_SIZE = 784
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop,
  input  logic [3:0] result,
  input  logic       key,
  input  logic [7:0] ram_q,
  output logic [9:0] ram_addr,
  output logic       tx,
  output logic       busy
);

  localparam int BW = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CNT - 1);
  localparam logic [9:0]    RES_LAST  = 10'd2;

`ifdef IMG_DUMP_EN
  localparam logic [9:0] IMG_LAST  = 10'(IMG_SIZE - 1);
  localparam logic [9:0] DUMP_LAST = 10'(IMG_SIZE + 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  function automatic logic [7:0] ascii_digit(input logic [3:0] r);
    return (r > 4'd9) ? 8'h3F : {4'h3, r};
  endfunction

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [9:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [7:0]      pend_byte_q, pend_byte_d;
  logic            tx_q, tx_d;
  logic [9:0]      last_idx;
  logic            baud_wrap;

`ifdef IMG_DUMP_EN
  logic            dump_q, dump_d;
  logic [9:0]      ram_addr_q, ram_addr_d;
`else
  logic            unused_dump_inputs;
  assign unused_dump_inputs = ^{key, ram_q};
`endif

  assign baud_wrap = (baud_q == BAUD_LAST);

`ifdef IMG_DUMP_EN
  assign last_idx = dump_q ? DUMP_LAST : RES_LAST;
  assign ram_addr = ram_addr_q;
`else
  assign last_idx = RES_LAST;
  assign ram_addr = '0;
`endif

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

  // State, counters and registered serial output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_byte_q <= '0;
      tx_q        <= 1'b1;
`ifdef IMG_DUMP_EN
      dump_q      <= 1'b0;
      ram_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      tx_q        <= tx_d;
`ifdef IMG_DUMP_EN
      dump_q      <= dump_d;
      ram_addr_q  <= ram_addr_d;
`endif
    end
  end

  // Next-state logic: message sequencing, bit timing and pending slot
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
`ifdef IMG_DUMP_EN
    dump_d      = dump_q;
    ram_addr_d  = ram_addr_q;
`endif

    case (state_q)
      IDLE: begin
        if (stop) begin
          shift_d = ascii_digit(result);
          cnt_d   = '0;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
`ifdef IMG_DUMP_EN
          dump_d  = 1'b0;
        end else if (key) begin
          dump_d     = 1'b1;
          cnt_d      = '0;
          ram_addr_d = '0;
          state_d    = LOAD;
`endif
        end
      end
`ifdef IMG_DUMP_EN
      // ram_addr already points at this byte, so ram_q is valid here; the
      // address is advanced immediately so the next read settles during
      // the frame instead of costing another wait cycle.
      LOAD: begin
        shift_d    = ram_q;
        ram_addr_d = (ram_addr_q == IMG_LAST) ? '0 : ram_addr_q + 10'd1;
        baud_d     = '0;
        bit_d      = '0;
        state_d    = START;
      end
`endif
      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          bit_d  = '0;
          if (cnt_q != last_idx) begin
            cnt_d = cnt_q + 10'd1;
`ifdef IMG_DUMP_EN
            if (dump_q && (cnt_q < IMG_LAST)) begin
              state_d = LOAD;
            end else
`endif
            begin
              shift_d = ((cnt_q + 10'd1) == last_idx) ? 8'h0A : 8'h0D;
              state_d = START;
            end
          end else if (pend_q) begin
            pend_d  = 1'b0;
            shift_d = pend_byte_q;
            cnt_d   = '0;
            state_d = START;
`ifdef IMG_DUMP_EN
            dump_d  = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Evaluated after the pending slot may have been consumed above, so a
    // stop on that same cycle refills it rather than being lost.
    if (stop && (state_q != IDLE)) begin
      pend_d      = 1'b1;
      pend_byte_d = ascii_digit(result);
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_result_tx_ctrl.sv
// Directed bench for result_tx_ctrl: decodes the tx line as a UART receiver
// and compares bytes, bit timing and busy length against hand values.
module tb_result_tx_ctrl;

  localparam int CLK = 15000000;
`ifdef IMG_DUMP_EN
  localparam int BC = 8;
`else
  localparam int BC = 130;
`endif
  localparam int MID    = 500 * BC / 130;
  localparam int RST_AT = 600 * BC / 130;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stop = 1'b0;
  logic [3:0] result = 4'd0;
  logic       key = 1'b0;
  logic [7:0] ram_q = 8'd0;
  logic [9:0] ram_addr;
  logic       tx;
  logic       busy;

  logic [7:0] mem [0:1023];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  result_tx_ctrl #(.CLK_FREQ(CLK), .BAUD(CLK / BC), .IMG_SIZE(784)) dut (
    .clk(clk), .rst(rst), .stop(stop), .result(result), .key(key),
    .ram_q(ram_q), .ram_addr(ram_addr), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ram_q <= mem[ram_addr];

  task automatic pulse(input bit s, input bit k, input logic [3:0] r, output int t);
    @(negedge clk);
    stop = s; key = k; result = r; t = cyc;
    @(posedge clk);
    #1;
    stop = 1'b0; key = 1'b0; result = 4'hA;
  endtask

  task automatic recv_byte(input int max_wait, output logic [7:0] d, output int t_start, output bit ok);
    ok = 1'b0; t_start = -1; d = 'x;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin ok = 1'b1; t_start = cyc; break; end
    end
    if (ok) begin
      repeat (BC / 2 - 1) @(negedge clk);
      if (tx !== 1'b0) ok = 1'b0;
      for (int b = 0; b < 8; b++) begin
        repeat (BC) @(negedge clk);
        d[b] = tx;
      end
      repeat (BC) @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || ram_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset tx=%b busy=%b ram_addr=%0d expected tx=1 busy=0 ram_addr=0", tx, busy, ram_addr);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_msg(input string name, input logic [3:0] r, input logic [7:0] first);
    logic [7:0] exp [3];
    logic [7:0] d;
    int t0, ts, tprev, tend, want;
    bit ok;
    exp[0] = first; exp[1] = 8'h0D; exp[2] = 8'h0A;
    tprev = 0;
    pulse(1'b1, 1'b0, r, t0);
    for (int n = 0; n < 3; n++) begin
      recv_byte((n == 0) ? 4 : 2 * BC, d, ts, ok);
      checks++;
      if (!ok || d !== exp[n]) begin
        errors++;
        $display("FAIL %s byte%0d got %h framing_ok=%0d expected %h", name, n, d, ok, exp[n]);
      end
      want = (n == 0) ? t0 + 1 : tprev + 10 * BC;
      checks++;
      if (ts != want) begin
        errors++;
        $display("FAIL %s start%0d at %0d expected %0d", name, n, ts, want);
      end
      tprev = ts;
    end
    for (int i = 0; i < 4 * BC && busy !== 1'b0; i++) @(negedge clk);
    tend = cyc;
    checks++;
    if (tend - t0 - 1 != 30 * BC) begin
      errors++;
      $display("FAIL %s busy_len got %0d expected %0d", name, tend - t0 - 1, 30 * BC);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [6];
    logic [7:0] got [6];
    int tst [6];
    bit okv [6];
    int t0, tx2, tend;
    exp[0] = 8'h33; exp[1] = 8'h0D; exp[2] = 8'h0A;
    exp[3] = 8'h35; exp[4] = 8'h0D; exp[5] = 8'h0A;
    pulse(1'b1, 1'b0, 4'd3, t0);
    fork
      begin
        repeat (MID - 1) @(negedge clk);
        pulse(1'b1, 1'b0, 4'd8, tx2);
        repeat (BC) @(negedge clk);
        pulse(1'b1, 1'b0, 4'd5, tx2);
      end
      begin
        for (int n = 0; n < 6; n++) begin
          logic [7:0] d; int ts; bit ok;
          recv_byte((n == 0) ? 4 : 2 * BC, d, ts, ok);
          got[n] = d; tst[n] = ts; okv[n] = ok;
        end
      end
    join
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (!okv[n] || got[n] !== exp[n]) begin
        errors++;
        $display("FAIL b2b byte%0d got %h framing_ok=%0d expected %h", n, got[n], okv[n], exp[n]);
      end
      if (n > 0) begin
        checks++;
        if (tst[n] != tst[n-1] + 10 * BC) begin
          errors++;
          $display("FAIL b2b start%0d at %0d expected %0d", n, tst[n], tst[n-1] + 10 * BC);
        end
      end
    end
    for (int i = 0; i < 4 * BC && busy !== 1'b0; i++) @(negedge clk);
    tend = cyc;
    checks++;
    if (tend - t0 - 1 != 60 * BC) begin
      errors++;
      $display("FAIL b2b busy_len got %0d expected %0d", tend - t0 - 1, 60 * BC);
    end
  endtask

  task automatic test_reset_midframe();
    int t0;
    pulse(1'b1, 1'b0, 4'd4, t0);
    repeat (RST_AT) @(negedge clk);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_pre tx=%b busy=%b expected tx=0 busy=1", tx, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_rst tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
    rst = 1'b0;
    repeat (2 * BC) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_idle tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
    test_msg("after_rst", 4'd1, 8'h31);
  endtask

`ifdef IMG_DUMP_EN
  task automatic test_key();
    logic [7:0] d;
    int t0, ts, bad, first_ts;
    bit ok;
    bad = 0; first_ts = -1;
    pulse(1'b0, 1'b1, 4'd0, t0);
    for (int n = 0; n < 784; n++) begin
      logic [7:0] e;
      e = 8'(n);
      recv_byte((n == 0) ? 6 : 2 * BC, d, ts, ok);
      if (n == 0) first_ts = ts;
      if (!ok || d !== e) bad++;
    end
    checks++;
    if (first_ts != t0 + 2) begin
      errors++;
      $display("FAIL dump_latency start at %0d expected %0d", first_ts, t0 + 2);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL dump_bytes bad_count %0d expected 0", bad);
    end
    recv_byte(2 * BC, d, ts, ok);
    checks++;
    if (!ok || d !== 8'h0D) begin
      errors++;
      $display("FAIL dump_cr got %h expected 0d", d);
    end
    recv_byte(2 * BC, d, ts, ok);
    checks++;
    if (!ok || d !== 8'h0A) begin
      errors++;
      $display("FAIL dump_lf got %h expected 0a", d);
    end
    for (int i = 0; i < 4 * BC && busy !== 1'b0; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ram_addr !== 10'd0) begin
      errors++;
      $display("FAIL dump_end busy=%b ram_addr=%0d expected busy=0 ram_addr=0", busy, ram_addr);
    end
  endtask
`else
  task automatic test_key();
    int t0, bad;
    bad = 0;
    pulse(1'b0, 1'b1, 4'd0, t0);
    for (int i = 0; i < 4 * BC; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || ram_addr !== 10'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL key_ignored active_cycles %0d expected 0", bad);
    end
  endtask
`endif

  task automatic test_stop_key();
    logic [7:0] exp [3];
    logic [7:0] d;
    int t0, ts, bad;
    bit ok;
    exp[0] = 8'h39; exp[1] = 8'h0D; exp[2] = 8'h0A;
    bad = 0;
    pulse(1'b1, 1'b1, 4'd9, t0);
    for (int n = 0; n < 3; n++) begin
      recv_byte((n == 0) ? 4 : 2 * BC, d, ts, ok);
      checks++;
      if (!ok || d !== exp[n]) begin
        errors++;
        $display("FAIL stop_key byte%0d got %h framing_ok=%0d expected %h", n, d, ok, exp[n]);
      end
    end
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 12 * BC; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stop_key_no_dump active_cycles %0d expected 0", bad);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 8'(a);
    test_reset();
    test_msg("digit7", 4'd7, 8'h37);
    test_msg("invalid12", 4'd12, 8'h3F);
    test_back_to_back();
    test_reset_midframe();
    test_key();
    test_stop_key();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
